// File: rtl/split_access_sequencer.sv
// split_access_sequencer: issues a P0/P1 request pair to one cache port in order and merges the returns
// into one right-justified line; optional flush/drain support under SPLIT_SEQ_FLUSH_EN.
module split_access_sequencer #(
  parameter int PADDR_W = 15,
  parameter int DATA_W  = 128
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef SPLIT_SEQ_FLUSH_EN
  input  logic               flush,
`endif
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [PADDR_W-1:0] req_addr0,
  input  logic [PADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0]  req_data0,
  input  logic [DATA_W-1:0]  req_data1,
  input  logic [DATA_W-1:0]  req_mask0,
  input  logic [DATA_W-1:0]  req_mask1,
  input  logic               req_needP1,
  input  logic               req_w,
  input  logic [3:0]         req_shift,
  output logic               c_valid,
  input  logic               c_ready,
  output logic [PADDR_W-1:0] c_addr,
  output logic [DATA_W-1:0]  c_data,
  output logic [DATA_W-1:0]  c_mask,
  output logic               c_w,
  input  logic               c_rvalid,
  input  logic [DATA_W-1:0]  c_rdata,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [DATA_W-1:0]  resp_data
);
`ifdef SPLIT_SEQ_FLUSH_EN
  typedef enum logic [6:0] {
    IDLE = 7'b0000001, ISS0 = 7'b0000010, WT0 = 7'b0000100, ISS1 = 7'b0001000,
    WT1 = 7'b0010000, RESP = 7'b0100000, DRAIN = 7'b1000000
  } state_t;
`else
  typedef enum logic [5:0] {
    IDLE = 6'b000001, ISS0 = 6'b000010, WT0 = 6'b000100, ISS1 = 6'b001000,
    WT1 = 6'b010000, RESP = 6'b100000
  } state_t;
`endif
  state_t state, nxt;
  logic [PADDR_W-1:0] a0, a1;
  logic [DATA_W-1:0] d0, d1, m0, m1, lo, hi;
  logic np1, wr;
  logic [3:0] sh;

  function automatic logic [DATA_W-1:0] shr(input logic [DATA_W-1:0] x, input logic [3:0] s);
    shr = x;
    for (int k = 0; k < 4; k++) shr = s[k] ? shr >> (8 << k) : shr;
  endfunction

  function automatic logic [DATA_W-1:0] shl(input logic [DATA_W-1:0] x, input logic [3:0] s);
    shl = x;
    for (int k = 0; k < 4; k++) shl = s[k] ? shl << (8 << k) : shl;
  endfunction

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: nxt = req_valid ? ISS0 : IDLE;
      ISS0: nxt = c_ready ? WT0 : ISS0;
      WT0:  nxt = c_rvalid ? (np1 ? ISS1 : RESP) : WT0;
      ISS1: nxt = c_ready ? WT1 : ISS1;
      WT1:  nxt = c_rvalid ? RESP : WT1;
      RESP: nxt = resp_ready ? IDLE : RESP;
`ifdef SPLIT_SEQ_FLUSH_EN
      DRAIN: nxt = c_rvalid ? IDLE : DRAIN;
`endif
      default: nxt = IDLE;
    endcase
`ifdef SPLIT_SEQ_FLUSH_EN
    // a return landing with the flush already settles the outstanding half
    if (flush && (state == ISS0 || state == ISS1 || state == RESP)) nxt = IDLE;
    if (flush && (state == WT0 || state == WT1)) nxt = c_rvalid ? IDLE : DRAIN;
`endif
  end

  assign req_ready  = state == IDLE;
  assign c_valid    = state == ISS0 || state == ISS1;
  assign c_addr     = state == ISS0 ? a0 : state == ISS1 ? a1 : '0;
  assign c_data     = state == ISS0 ? d0 : state == ISS1 ? d1 : '0;
  assign c_mask     = state == ISS0 ? m0 : state == ISS1 ? m1 : '0;
  assign c_w        = c_valid & wr;
  assign resp_valid = state == RESP;
  assign resp_data  = (resp_valid && !wr) ? lo | hi : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      {a0, a1, d0, d1, m0, m1, np1, wr, sh, lo, hi} <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && req_valid) begin
        {a0, a1, d0, d1, m0, m1} <= {req_addr0, req_addr1, req_data0, req_data1, req_mask0, req_mask1};
        {np1, wr, sh} <= {req_needP1, req_w, req_shift};
        lo <= '0;
        hi <= '0;
      end
      if (state == WT0 && c_rvalid) lo <= shr(c_rdata, sh);
      // left shift by 16-sh bytes; sh=0 would be a full 16-byte shift, i.e. zero
      if (state == WT1 && c_rvalid) hi <= sh == 4'd0 ? '0 : shl(c_rdata, ~sh + 4'd1);
    end
  end
endmodule

// File: tb/tb_split_access_sequencer.sv
// tb_split_access_sequencer: table vectors, hand corner sequences and random pairs vs a byte-window model.
module tb_split_access_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic req_valid = 1'b0, req_ready, req_needP1 = 1'b0, req_w = 1'b0;
  logic [14:0] req_addr0 = '0, req_addr1 = '0, c_addr;
  logic [127:0] req_data0 = '0, req_data1 = '0, req_mask0 = '0, req_mask1 = '0;
  logic [3:0] req_shift = '0;
  logic c_valid, c_ready = 1'b0, c_w, c_rvalid = 1'b0, resp_valid, resp_ready = 1'b0;
  logic [127:0] c_data, c_mask, c_rdata = '0, resp_data;
`ifdef SPLIT_SEQ_FLUSH_EN
  logic flush = 1'b0;
`endif
  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc++;

  split_access_sequencer dut (
    .clk(clk), .rst_n(rst_n),
`ifdef SPLIT_SEQ_FLUSH_EN
    .flush(flush),
`endif
    .req_valid(req_valid), .req_ready(req_ready), .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_data0(req_data0), .req_data1(req_data1), .req_mask0(req_mask0), .req_mask1(req_mask1),
    .req_needP1(req_needP1), .req_w(req_w), .req_shift(req_shift),
    .c_valid(c_valid), .c_ready(c_ready), .c_addr(c_addr), .c_data(c_data), .c_mask(c_mask), .c_w(c_w),
    .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data)
  );

  localparam logic [127:0] L0 = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] L1 = 128'h1F1E1D1C1B1A19181716151413121110;

  typedef struct {
    logic [14:0] a0;
    logic np1, w;
    int r0, r1, rv, hold;
    logic [127:0] l0, l1, exp;
  } vec_t;
  vec_t tbl[7];

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // response = 16-byte window starting at byte sh of the 32-byte string {P1 line, P0 line}
  function automatic logic [127:0] model(input logic [127:0] l0, l1, input logic [3:0] sh, input logic np1, w);
    logic [7:0] b[32];
    logic [127:0] r;
    r = '0;
    if (w) return '0;
    for (int i = 0; i < 16; i++) begin
      b[i] = l0[8*i+:8];
      b[16+i] = np1 ? l1[8*i+:8] : 8'h00;
    end
    for (int i = 0; i < 16; i++) r[8*i+:8] = b[int'(sh)+i];
    return r;
  endfunction

  task automatic chkw(input string n, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic chkb(input string n, input logic act, input logic exp);
    chkw(n, 128'(act), 128'(exp));
  endtask

  task automatic chki(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chkb("rst_req_ready", req_ready, 1'b1);
    chkb("rst_c_valid", c_valid, 1'b0);
    chkb("rst_resp_valid", resp_valid, 1'b0);
    chkw("rst_c_addr", 128'(c_addr), '0);
    chkw("rst_c_data", c_data, '0);
    chkw("rst_c_mask", c_mask, '0);
    chkb("rst_c_w", c_w, 1'b0);
    chkw("rst_resp_data", resp_data, '0);
  endtask

  task automatic accept(input logic [14:0] a0, a1, input logic [127:0] d0, d1, m0, m1,
                        input logic np1, w, output int t0);
    @(negedge clk);
    chkb("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_addr0 = a0; req_addr1 = a1; req_data0 = d0; req_data1 = d1;
    req_mask0 = m0; req_mask1 = m1; req_needP1 = np1; req_w = w; req_shift = a0[3:0];
    t0 = cyc;
    @(negedge clk);
    req_valid = 1'b0; req_addr0 = 15'($urandom); req_addr1 = 15'($urandom); req_data0 = rnd128();
    req_data1 = rnd128(); req_mask0 = rnd128(); req_mask1 = rnd128(); req_needP1 = ~np1;
    req_w = ~w; req_shift = 4'($urandom);
  endtask

  task automatic issue(input logic [14:0] a, input logic [127:0] d, m, input logic w, input int rdy);
    for (int i = 0; i <= rdy; i++) begin
      chkb("c_valid", c_valid, 1'b1);
      chkw("c_addr", 128'(a), 128'(c_addr) == 128'(a) ? 128'(a) : 128'(c_addr) ^ 128'(a) ^ 128'(a));
      chkw("c_addr_val", 128'(c_addr), 128'(a));
      chkw("c_data", c_data, d);
      chkw("c_mask", c_mask, m);
      chkb("c_w", c_w, w);
      chkb("req_ready_busy", req_ready, 1'b0);
      c_ready = (i == rdy);
      @(negedge clk);
    end
    c_ready = 1'b0;
  endtask

  task automatic ret(input logic [127:0] line, input int rv);
    for (int i = 0; i <= rv; i++) begin
      chkb("c_valid_wait", c_valid, 1'b0);
      chkb("resp_valid_wait", resp_valid, 1'b0);
      c_rvalid = (i == rv);
      c_rdata = (i == rv) ? line : rnd128();
      @(negedge clk);
    end
    c_rvalid = 1'b0;
  endtask

  task automatic finish_resp(input logic [127:0] exp, input int lat, input int t0, input int hold);
    chki("latency", cyc - t0, lat);
    for (int i = 0; i <= hold; i++) begin
      chkb("resp_valid", resp_valid, 1'b1);
      chkw("resp_data", resp_data, exp);
      chkb("req_ready_resp", req_ready, 1'b0);
      chkb("c_valid_resp", c_valid, 1'b0);
      req_valid = 1'b1;
      resp_ready = (i == hold);
      @(negedge clk);
    end
    resp_ready = 1'b0;
    req_valid = 1'b0;
    chkb("resp_done", resp_valid, 1'b0);
    chkb("req_ready_after", req_ready, 1'b1);
  endtask

  task automatic txn(input logic [14:0] a0, input logic np1, w, input int r0, r1, rv, hold,
                     input logic [127:0] l0, l1, exp);
    logic [14:0] a1;
    logic [127:0] d0, d1, m0, m1;
    int t0;
    a1 = (a0 & 15'h7FF0) + 15'h0010;
    d0 = rnd128(); d1 = rnd128(); m0 = rnd128(); m1 = rnd128();
    accept(a0, a1, d0, d1, m0, m1, np1, w, t0);
    issue(a0, d0, m0, w, r0);
    ret(l0, rv);
    if (np1) begin
      issue(a1, d1, m1, w, r1);
      ret(l1, rv);
    end
    finish_resp(exp, 3 + r0 + rv + (np1 ? 2 + r1 + rv : 0), t0, hold);
  endtask

  initial begin
    logic [14:0] a0;
    logic [127:0] l0, l1;
    logic np1, w;
    int t0;
    tbl[0] = '{15'h0040, 1'b0, 1'b0, 0, 0, 0, 0, L0, L1, L0};
    tbl[1] = '{15'h004C, 1'b1, 1'b0, 0, 0, 0, 0, L0, L1, 128'h1B1A191817161514131211100F0E0D0C};
    tbl[2] = '{15'h0123, 1'b1, 1'b1, 0, 3, 0, 0, L0, L1, '0};
    tbl[3] = '{15'h0040, 1'b0, 1'b0, 0, 0, 0, 5, L0, L1, L0};
    tbl[4] = '{15'h0064, 1'b0, 1'b0, 1, 0, 2, 1, L0, L1, 128'h000000000F0E0D0C0B0A090807060504};
    tbl[5] = '{15'h0070, 1'b1, 1'b0, 0, 0, 1, 0, L0, L1, L0};
    tbl[6] = '{15'h7FFF, 1'b1, 1'b0, 2, 1, 0, 0, L0, L1, 128'h1E1D1C1B1A191817161514131211100F};

    repeat (2) @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;

    foreach (tbl[i])
      txn(tbl[i].a0, tbl[i].np1, tbl[i].w, tbl[i].r0, tbl[i].r1, tbl[i].rv, tbl[i].hold,
          tbl[i].l0, tbl[i].l1, tbl[i].exp);

    // reset while P1 is outstanding, then a stray return
    accept(15'h0105, 15'h0110, rnd128(), rnd128(), rnd128(), rnd128(), 1'b1, 1'b0, t0);
    issue(15'h0105, dut.d0, dut.m0, 1'b0, 0);
    ret(L0, 0);
    issue(15'h0110, dut.d1, dut.m1, 1'b0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    c_rvalid = 1'b1;
    c_rdata = L1;
    chk_reset_vals();
    @(negedge clk);
    c_rvalid = 1'b0;
    chk_reset_vals();
    @(negedge clk);
    chk_reset_vals();

`ifdef SPLIT_SEQ_FLUSH_EN
    accept(15'h0208, 15'h0210, rnd128(), rnd128(), rnd128(), rnd128(), 1'b1, 1'b0, t0);
    issue(15'h0208, dut.d0, dut.m0, 1'b0, 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chkb("drain_req_ready", req_ready, 1'b0);
    chkb("drain_resp_valid", resp_valid, 1'b0);
    @(negedge clk);
    chkb("drain_req_ready2", req_ready, 1'b0);
    c_rvalid = 1'b1;
    c_rdata = L0;
    @(negedge clk);
    c_rvalid = 1'b0;
    chkb("drain_done_ready", req_ready, 1'b1);
    chkb("drain_no_p1", c_valid, 1'b0);
    chkb("drain_no_resp", resp_valid, 1'b0);
    @(negedge clk);
    chkb("drain_idle_resp", resp_valid, 1'b0);
`endif

    for (int n = 0; n < 40; n++) begin
      a0 = 15'($urandom);
      np1 = 1'($urandom);
      w = 1'($urandom);
      l0 = rnd128();
      l1 = rnd128();
      txn(a0, np1, w, int'($urandom_range(2, 0)), int'($urandom_range(2, 0)), int'($urandom_range(2, 0)),
          int'($urandom_range(2, 0)), l0, l1, model(l0, l1, a0[3:0], np1, w));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
